// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: registered pipeline FIFO with valid/allowin handshake and flush.
// Define PIPE_STAGE_FIFO_PERF_EN to add the 32-bit saturating stall_cnt output.
module pipe_stage_fifo #(
  parameter int BUS_W = 64,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [BUS_W-1:0]        in_bus,
  output logic                    in_allowin,
  output logic                    out_valid,
  output logic [BUS_W-1:0]        out_bus,
  input  logic                    out_allowin,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count
`ifdef PIPE_STAGE_FIFO_PERF_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign out_valid  = (count != '0);
  assign out_bus    = mem[rd_ptr];
  assign pop        = out_valid & out_allowin;
  // Reset holds allowin low so nothing is taken while state is cleared.
  assign in_allowin = resetn & ~flush & ((count < FULL) | pop);
  assign push       = in_valid & in_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_bus;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PIPE_STAGE_FIFO_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (out_valid & ~out_allowin & (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: queue-model scoreboard plus directed literal checks.
// Connects stall_cnt when PIPE_STAGE_FIFO_PERF_EN is defined.
module tb_pipe_stage_fifo;

  localparam int BW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_bus = '0;
  logic          out_allowin = 1'b0;
  logic          flush = 1'b0;
  logic          in_allowin;
  logic          out_valid;
  logic [BW-1:0] out_bus;
  logic [2:0]    count;
`ifdef PIPE_STAGE_FIFO_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [BW-1:0] q[$];
  logic [BW-1:0] popped[$];
  logic [31:0]   m_stall = 0;
  int            m_c;
  bit            m_v, m_a, m_po, m_pu;

  always #5 clk = ~clk;

  pipe_stage_fifo #(.BUS_W(BW), .DEPTH(D)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_bus     (in_bus),
    .in_allowin (in_allowin),
    .out_valid  (out_valid),
    .out_bus    (out_bus),
    .out_allowin(out_allowin),
    .flush      (flush),
    .count      (count)
`ifdef PIPE_STAGE_FIFO_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Scoreboard: check this cycle against the queue, then advance it.
  always @(negedge clk) begin
    if (!resetn) begin
      check("rst_count", 32'(count), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_allowin", 32'(in_allowin), 0);
      check("rst_bus", 32'(out_bus), 0);
`ifdef PIPE_STAGE_FIFO_PERF_EN
      check("rst_stall", stall_cnt, 0);
`endif
      q.delete();
      m_stall = 0;
    end else begin
      m_c  = q.size();
      m_v  = (m_c != 0);
      m_po = m_v && out_allowin;
      m_a  = !flush && ((m_c < D) || m_po);
      m_pu = in_valid && m_a;
      check("count", 32'(count), 32'(m_c));
      check("out_valid", 32'(out_valid), 32'(m_v));
      check("in_allowin", 32'(in_allowin), 32'(m_a));
      if (m_v) check("out_bus", 32'(out_bus), 32'(q[0]));
`ifdef PIPE_STAGE_FIFO_PERF_EN
      check("stall_cnt", stall_cnt, m_stall);
`endif
      if (m_v && !out_allowin && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (m_po) popped.push_back(q[0]);
      if (flush) begin
        q.delete();
      end else begin
        if (m_po) void'(q.pop_front());
        if (m_pu) q.push_back(in_bus);
      end
    end
  end

  task automatic drive(input logic v, input logic [BW-1:0] d,
                       input logic oa, input logic fl);
    @(posedge clk);
    #1;
    in_valid    = v;
    in_bus      = d;
    out_allowin = oa;
    flush       = fl;
  endtask

  initial begin
    int k;
    #3;
    check("t0_count", 32'(count), 0);
    check("t0_allowin", 32'(in_allowin), 0);
    check("t0_bus", 32'(out_bus), 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("allowin_after_reset", 32'(in_allowin), 1);

    // Latency: no same-cycle bypass.
    drive(1'b1, 16'h5, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_valid_t", 32'(out_valid), 0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_valid_t1", 32'(out_valid), 1);
    check("lat_bus_t1", 32'(out_bus), 32'h5);
    drive(1'b0, 16'h0, 1'b1, 1'b0);

    // Fill to full, then push with simultaneous pop.
    drive(1'b1, 16'hA, 1'b0, 1'b0);
    drive(1'b1, 16'hB, 1'b0, 1'b0);
    drive(1'b1, 16'hC, 1'b0, 1'b0);
    drive(1'b1, 16'hD, 1'b0, 1'b0);
    drive(1'b1, 16'hE, 1'b0, 1'b0);
    @(negedge clk);
    check("full_count", 32'(count), 4);
    check("full_allowin", 32'(in_allowin), 0);
    check("full_bus", 32'(out_bus), 32'hA);
    drive(1'b1, 16'hE, 1'b1, 1'b0);
    @(negedge clk);
    check("full_pushpop_allowin", 32'(in_allowin), 1);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("full_pushpop_count", 32'(count), 4);
    check("full_pushpop_bus", 32'(out_bus), 32'hB);

    // Flush with a push attempt at count 3.
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b1, 16'h77, 1'b0, 1'b1);
    @(negedge clk);
    check("flush_count_t", 32'(count), 3);
    check("flush_allowin", 32'(in_allowin), 0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_count_t1", 32'(count), 0);
    check("flush_valid_t1", 32'(out_valid), 0);

    // Order through pointer wrap with random backpressure.
    popped.delete();
    k = 1;
    for (int cyc = 0; cyc < 200 && popped.size() < 6; cyc++) begin
      if (k <= 6) drive(1'b1, 16'(k), 1'($urandom_range(0, 1)), 1'b0);
      else        drive(1'b0, 16'h0, 1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      if (k <= 6 && in_allowin) k++;
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("order_n", 32'(popped.size()), 6);
    for (int i = 0; i < 6 && i < popped.size(); i++)
      check("order_item", 32'(popped[i]), 32'(i + 1));

    // Asynchronous reset mid-cycle with two entries held.
    drive(1'b1, 16'h11, 1'b0, 1'b0);
    drive(1'b1, 16'h22, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    check("pre_rst_count", 32'(count), 2);
    resetn = 1'b0;
    #1;
    check("async_count", 32'(count), 0);
    check("async_valid", 32'(out_valid), 0);
    check("async_allowin", 32'(in_allowin), 0);
    check("async_bus", 32'(out_bus), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("allowin_after_rst2", 32'(in_allowin), 1);

    // Ten stalled cycles, then a flush that pops.
    drive(1'b1, 16'h33, 1'b0, 1'b0);
    repeat (10) drive(1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    @(negedge clk);
`ifdef PIPE_STAGE_FIFO_PERF_EN
    check("stall_10", stall_cnt, 10);
`endif
    check("stall_head", 32'(out_bus), 32'h33);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_flush_count", 32'(count), 0);
`ifdef PIPE_STAGE_FIFO_PERF_EN
    check("stall_after_flush", stall_cnt, 10);
`endif

    // Random traffic against the queue model.
    repeat (400) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_fifo.md
PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

Interface
REQ-001 Parameter BUS_W, default 64: data bus width in bits; legal range 1..256.
REQ-002 Parameter DEPTH, default 2: entry count; SHALL be a power of two, 2..16.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port resetn, input, 1: reset; SHALL be asynchronous and active-low.
REQ-005 Port in_valid, input, 1: upstream presents a valid item on in_bus.
REQ-006 Port in_bus, input, BUS_W: upstream payload.
REQ-007 Port in_allowin, output, 1: block accepts an item this cycle.
REQ-008 Port out_valid, output, 1: head entry is valid.
REQ-009 Port out_bus, output, BUS_W: head entry payload.
REQ-010 Port out_allowin, input, 1: downstream accepts the head this cycle.
REQ-011 Port flush, input, 1: discard all held and incoming items.
REQ-012 Port count, output, $clog2(DEPTH)+1: number of valid entries.

Function
REQ-013 push = in_valid & in_allowin; pop = out_valid & out_allowin; both SHALL be evaluated in the same cycle.
REQ-014 out_valid SHALL equal (count != 0); out_bus SHALL be the entry at the read pointer, read combinationally from registered storage.
REQ-015 in_allowin SHALL equal ~flush & ((count < DEPTH) | pop); a push when full is legal only with a simultaneous pop.
REQ-016 Latency: an item pushed in cycle t SHALL first appear on out_bus/out_valid in cycle t+1; there is no same-cycle bypass.
REQ-017 Order SHALL be strictly FIFO; items are never dropped or duplicated except by flush.
REQ-018 Push only: write at write pointer, write pointer +1, count +1.
REQ-019 Pop only: read pointer +1, count -1.
REQ-020 Push and pop together: both pointers advance; count unchanged. This is legal at count = DEPTH; at count = 0 no pop can occur.
REQ-021 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without extra logic.
REQ-022 flush high in cycle t: count and both pointers SHALL be 0 in cycle t+1; out_valid SHALL be 0 in t+1; any pop in t is still a valid downstream transfer; in_bus in t is ignored.
REQ-023 Storage contents SHALL NOT be cleared by flush; only the pointers and count reset.
REQ-024 out_bus when out_valid = 0 is don't-care; downstream SHALL NOT sample it.

Reset
REQ-025 resetn low SHALL immediately, without a clock, force count = 0, both pointers = 0, out_valid = 0, in_allowin = 0, and all storage entries = 0 (so out_bus = 0).
REQ-026 resetn deasserted SHALL make in_allowin = 1 combinationally while flush = 0; the first push is accepted on the first rising edge after deassertion.
REQ-027 Reset asserted mid-operation SHALL discard all entries; no partial transfer survives.

Configuration
REQ-028 Macro PIPE_STAGE_FIFO_PERF_EN defined: the block SHALL add output stall_cnt, 32 bits. It increments each cycle with out_valid & ~out_allowin, saturates at 0xFFFFFFFF, and is cleared only by reset (not by flush). When not defined, the port and its counter SHALL be absent and the other behaviour SHALL be unchanged.

Verification
REQ-029 DEPTH = 2, out_allowin = 0, push 0xA, 0xB -> count = 2, in_allowin = 0, out_bus = 0xA; then out_allowin = 1 with in_valid 0xC -> 0xC accepted, count stays 2, next out_bus = 0xB.
REQ-030 DEPTH = 4, push 6 items with random out_allowin -> output order is 1..6, and write and read pointers wrap past 3 correctly.
REQ-031 count = 3 with flush = 1 and in_valid = 1 in the same cycle -> in_allowin = 0, and in the next cycle count = 0 and out_valid = 0.
REQ-032 Push 0x5 at cycle t -> out_valid = 0 at t and out_valid = 1 with out_bus = 0x5 at t+1.
REQ-033 Assert resetn = 0 asynchronously between clock edges with count = 2 -> outputs reach their reset values before the next edge.
REQ-034 PIPE_STAGE_FIFO_PERF_EN defined, out_valid = 1 and out_allowin = 0 for 10 cycles -> stall_cnt = 10; a flush leaves stall_cnt at 10.
